// File: rtl/result_drain_pkg.sv
// Shared types and derived sizes for the result drain.
// MAX_DIM is always BUS_WIDTH/DATA_WIDTH and cannot be overridden on its own.
package result_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_STAT = 2'd2
  } state_e;

  function automatic int calc_max_dim(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  function automatic int calc_n_elem(input int bus_width, input int data_width);
    return calc_max_dim(bus_width, data_width) * calc_max_dim(bus_width, data_width);
  endfunction

  function automatic int calc_idx_w(input int bus_width, input int data_width);
    int n;
    n = calc_n_elem(bus_width, data_width);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W = calc_idx_w(32, 8);

endpackage

// File: rtl/result_drain_if.sv
// Output stream of the result drain: one element per valid/ready transfer.
interface result_drain_if
  import result_drain_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int IDX_W     = DEF_IDX_W
);
  logic [BUS_WIDTH-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 last;
  logic                 ouflow_elem;
  logic [IDX_W-1:0]     idx;

  modport master (output data, valid, last, ouflow_elem, idx, input ready);
  modport slave  (input data, valid, last, ouflow_elem, idx, output ready);
endinterface

// File: rtl/result_drain_sel.sv
// drain_sel: picks element idx (row-major, (0,0) in the MSB slice) and its
// overflow flag (bit N_ELEM-1 = element (0,0)) out of the snapshot.
module drain_sel #(
  parameter int BUS_WIDTH = 32,
  parameter int N_ELEM    = 16,
  parameter int IDX_W     = 4
) (
  input  logic [N_ELEM*BUS_WIDTH-1:0] snap_r_i,
  input  logic [N_ELEM-1:0]           snap_f_i,
  input  logic [IDX_W-1:0]            idx_i,
  output logic [BUS_WIDTH-1:0]        elem_o,
  output logic                        flag_o
);
  logic [IDX_W-1:0] rev_idx;

  // Element 0 lives in the top slice, so index from the MSB end.
  always_comb begin
    rev_idx = IDX_W'(N_ELEM - 1) - idx_i;
    elem_o  = snap_r_i[rev_idx*BUS_WIDTH +: BUS_WIDTH];
    flag_o  = snap_f_i[rev_idx];
  end
endmodule

// File: rtl/result_drain.sv
// result_drain: snapshots the systolic result on the rising edge of done_i and
// streams it out one element per transfer, so the array may restart at once.
// Optional feature macro: RESULT_DRAIN_SUMMARY_EN appends one summary word
// (all overflow flags) after the last element and moves last to it.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       done_i,
  input  logic [calc_n_elem(BUS_WIDTH, DATA_WIDTH)*BUS_WIDTH-1:0] fin_r_i,
  input  logic [calc_n_elem(BUS_WIDTH, DATA_WIDTH)-1:0]           ouflow_i,
  result_drain_if.master             out_if,
  output logic                       busy_o,
  output logic                       overrun_o
);
  localparam int MAX_DIM = calc_max_dim(BUS_WIDTH, DATA_WIDTH);
  localparam int N_ELEM  = MAX_DIM * MAX_DIM;
  localparam int IDX_W   = calc_idx_w(BUS_WIDTH, DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

`ifdef RESULT_DRAIN_SUMMARY_EN
  localparam bit SUMMARY_EN = 1'b1;
  if (N_ELEM > BUS_WIDTH) begin : g_bad_cfg
    $error("result_drain: summary word needs MAX_DIM*MAX_DIM <= BUS_WIDTH");
  end
`else
  localparam bit SUMMARY_EN = 1'b0;
`endif

  state_e                      state_q, state_d;
  logic                        done_q;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [N_ELEM*BUS_WIDTH-1:0] snap_r_q, snap_r_d;
  logic [N_ELEM-1:0]           snap_f_q, snap_f_d;
  logic                        overrun_q, overrun_d;
  logic                        start;
  logic [BUS_WIDTH-1:0]        sel_elem;
  logic                        sel_flag;

  drain_sel #(
    .BUS_WIDTH (BUS_WIDTH),
    .N_ELEM    (N_ELEM),
    .IDX_W     (IDX_W)
  ) u_sel (
    .snap_r_i (snap_r_q),
    .snap_f_i (snap_f_q),
    .idx_i    (idx_q),
    .elem_o   (sel_elem),
    .flag_o   (sel_flag)
  );

  // Next-state logic: capture on a done edge in IDLE, step idx on each handshake.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d   = state_q;
    idx_d     = idx_q;
    snap_r_d  = snap_r_q;
    snap_f_d  = snap_f_q;
    overrun_d = 1'b0;
    start     = done_i & ~done_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_r_d = fin_r_i;
          snap_f_d = ouflow_i;
          idx_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        overrun_d = start;
        if (out_if.ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = SUMMARY_EN ? ST_STAT : ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_STAT: begin
        overrun_d = start;
        if (out_if.ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; a reset abandons any drain in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the snapshot is reset too, so outputs and state are fully defined after reset.
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      idx_q     <= '0;
      snap_r_q  <= '0;
      snap_f_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      done_q    <= done_i;
      idx_q     <= idx_d;
      snap_r_q  <= snap_r_d;
      snap_f_q  <= snap_f_d;
      overrun_q <= overrun_d;
    end
  end

  // Output decode: data/flags only meaningful (and non-zero) while valid.
  always_comb begin
    out_if.valid       = (state_q != ST_IDLE);
    out_if.idx         = idx_q;
    out_if.data        = '0;
    out_if.ouflow_elem = 1'b0;
    out_if.last        = 1'b0;
    busy_o             = (state_q != ST_IDLE);
    overrun_o          = overrun_q;
    case (state_q)
      ST_SEND: begin
        out_if.data        = sel_elem;
        out_if.ouflow_elem = sel_flag;
        out_if.last        = ~SUMMARY_EN & (idx_q == LAST_IDX);
      end
      ST_STAT: begin
        out_if.data        = BUS_WIDTH'(snap_f_q);
        out_if.ouflow_elem = |snap_f_q;
        out_if.last        = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: directed scenarios with randomized data
// and ready, checked against an expected-word queue built from the matrix.
module tb_result_drain;
  import result_drain_pkg::*;

  localparam int BW = 32;
  localparam int DW = 8;
  localparam int MD = BW / DW;
  localparam int NE = MD * MD;
  localparam int IW = $clog2(NE);
`ifdef RESULT_DRAIN_SUMMARY_EN
  localparam int NW = NE + 1;
`else
  localparam int NW = NE;
`endif

  typedef struct packed {
    logic [BW-1:0] data;
    logic          flag;
    logic [IW-1:0] idx;
    logic          last;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             done_i;
  logic [NE*BW-1:0] fin_r_i;
  logic [NE-1:0]    ouflow_i;
  logic             busy;
  logic             overrun;
  int               vectors = 0;
  int               miscompares = 0;
  int               n_cyc;
  logic [BW-1:0]    elem [NE];
  word_t            exp_q [$];

  result_drain_if #(.BUS_WIDTH(BW), .IDX_W(IW)) dif ();

  result_drain #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .done_i    (done_i),
    .fin_r_i   (fin_r_i),
    .ouflow_i  (ouflow_i),
    .out_if    (dif.master),
    .busy_o    (busy),
    .overrun_o (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build a new matrix and the word sequence the drain must produce for it.
  task automatic load(input bit rnd);
    for (int k = 0; k < NE; k++) begin
      elem[k] = rnd ? $urandom : 32'h100 + k;
      fin_r_i[(NE-1-k)*BW +: BW] = elem[k];
    end
    ouflow_i = rnd ? NE'($urandom) : NE'(16'h8001);
    exp_q.delete();
    for (int k = 0; k < NE; k++)
      exp_q.push_back('{elem[k], ouflow_i[NE-1-k], IW'(k), (k == NE-1) && (NW == NE)});
    if (NW > NE) exp_q.push_back('{BW'(ouflow_i), |ouflow_i, IW'(0), 1'b1});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(dif.valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_last"}, 32'(dif.last), 32'd0);
    check({tag, "_data"}, dif.data, 32'd0);
  endtask

  // Consume words until stop_at handshakes are committed; optionally raise a
  // second done edge while word ovr_at is on the bus.
  task automatic drain(input int stop_at, input bit rnd_ready, input bit hold_done,
                       input int ovr_at, output int cycles);
    int            widx = 0;
    bit            exp_ovr = 1'b0;
    bit            ovr_done = 1'b0;
    bit            stalled = 1'b0;
    logic [BW-1:0] prev = '0;
    cycles = 0;
    forever begin
      if (cycles > 400) begin
        vectors++;
        miscompares++;
        $error("FAIL drain_timeout observed=%0d words expected=%0d", widx, stop_at);
        break;
      end
      check("valid", 32'(dif.valid), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("data", dif.data, exp_q[widx].data);
      check("flag", 32'(dif.ouflow_elem), 32'(exp_q[widx].flag));
      check("idx", 32'(dif.idx), 32'(exp_q[widx].idx));
      check("last", 32'(dif.last), 32'(exp_q[widx].last));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      if (stalled) check("hold", dif.data, prev);
      exp_ovr = 1'b0;
      if (widx == ovr_at && !ovr_done) begin
        done_i   = 1'b1;
        fin_r_i  = ~fin_r_i;
        ouflow_i = ~ouflow_i;
        ovr_done = 1'b1;
        exp_ovr  = 1'b1;
      end else if (!hold_done) begin
        done_i = 1'b0;
      end
      dif.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev      = dif.data;
      stalled   = !dif.ready;
      if (dif.ready) widx++;
      cycles++;
      if (widx == stop_at) break;
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    done_i    = 1'b0;
    fin_r_i   = '0;
    ouflow_i  = '0;
    dif.ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    check_idle("rst");
    check("rst_flag", 32'(dif.ouflow_elem), 32'd0);
    check("rst_idx", 32'(dif.idx), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // done high at reset release is a start; full-rate drain.
    load(1'b0);
    done_i = 1'b1;
    rst_n  = 1'b1;
    tick();
    drain(NW, 1'b0, 1'b0, -1, n_cyc);
    check("fullrate_cycles", 32'(n_cyc), 32'(NW));
    tick();
    check_idle("end1");

    // Start in the very cycle after the final handshake, random data and ready.
    load(1'b1);
    done_i = 1'b1;
    tick();
    drain(NW, 1'b1, 1'b0, -1, n_cyc);
    tick();
    check_idle("end2");

    // Second done edge while word 5 is presented: overrun, snapshot untouched.
    load(1'b0);
    done_i = 1'b1;
    tick();
    drain(NW, 1'b0, 1'b0, 5, n_cyc);
    tick();
    check_idle("end3");
    check("end3_overrun", 32'(overrun), 32'd0);

    // Reset at word 8 clears everything at once; then a fresh drain.
    load(1'b1);
    done_i = 1'b1;
    tick();
    drain(8, 1'b1, 1'b0, -1, n_cyc);
    tick();
    check("pre_rst_idx", 32'(dif.idx), 32'd8);
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    check("midrst_idx", 32'(dif.idx), 32'd0);
    check("midrst_flag", 32'(dif.ouflow_elem), 32'd0);
    tick();
    rst_n = 1'b1;
    load(1'b1);
    done_i = 1'b1;
    tick();
    drain(NW, 1'b1, 1'b0, -1, n_cyc);
    tick();
    check_idle("end4");

    // done held high across the end of a drain: no restart until a new edge.
    done_i = 1'b0;
    tick();
    load(1'b1);
    done_i = 1'b1;
    tick();
    drain(NW, 1'b1, 1'b1, -1, n_cyc);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("held_valid", 32'(dif.valid), 32'd0);
      tick();
    end
    done_i = 1'b0;
    tick();
    load(1'b0);
    done_i = 1'b1;
    tick();
    drain(NW, 1'b0, 1'b0, -1, n_cyc);
    tick();
    check_idle("end5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/result_drain.md
# result_drain

Drains the flattened AB+C result matrix and per-element overflow flags produced by the systolic multiplier when it signals done, and streams them out one BUS_WIDTH element per transfer over a valid/ready interface. It sits at the output side of the half multiplier, after the systolic array, mirroring the input pushers. It snapshots the result so the array may restart while draining continues.

## Interface
- BUS_WIDTH, 32, width of one result element and of the output data bus
- DATA_WIDTH, 8, operand chunk width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (derived, not overridable)
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- done_i  input  1  systolic done flag (level); its rising edge starts a drain
- fin_r_i  input  MAX_DIM*MAX_DIM*BUS_WIDTH  flattened result, element (0,0) in the MSB slice, row-major
- ouflow_i  input  MAX_DIM*MAX_DIM  overflow flags, bit MAX_DIM*MAX_DIM-1 = element (0,0)
- ready_i  input  1  downstream ready
- data_o  output  BUS_WIDTH  current element
- valid_o  output  1  data_o/ouflow_elem_o/last_o/idx_o valid
- last_o  output  1  final word of the drain
- ouflow_elem_o  output  1  overflow flag of the current element
- idx_o  output  clog2(MAX_DIM*MAX_DIM)  index of the current element, 0 = (0,0)
- busy_o  output  1  drain in progress
- overrun_o  output  1  one-cycle pulse: done rising edge arrived while busy

## Operation
- States: IDLE, SEND (plus STAT when configured).
- done_q registers done_i; start = done_i & ~done_q.
- IDLE: on start, capture fin_r_i and ouflow_i into snapshot registers, idx = 0, go to SEND.
- SEND: valid_o = 1; data_o = snapshot slice idx (MSB-first), ouflow_elem_o = snapshot flag idx. On valid_o & ready_i: if idx = MAX_DIM*MAX_DIM-1 go to IDLE (or STAT), else idx+1.
- last_o = 1 only on the final word of the drain.
- Outputs held stable while valid_o & ~ready_i; no word dropped or repeated.
- start while SEND/STAT: ignored, snapshot untouched, overrun_o pulses.
- done_i held high across end of drain: no restart (edge-triggered only).
- Reset mid-drain: all state cleared asynchronously, drain abandoned.

## Timing
- Reset values: data_o 0, valid_o 0, last_o 0, ouflow_elem_o 0, idx_o 0, busy_o 0, overrun_o 0; done_q 0, so done_i high at reset release counts as a start.
- Start edge sampled at clock k -> valid_o and busy_o high from cycle k+1.
- With ready_i constantly 1: one word per cycle, MAX_DIM*MAX_DIM cycles (16 at defaults).
- Cycle after final handshake: valid_o 0, busy_o 0; a start in that cycle is accepted (next drain valid one cycle later). Minimum gap between drains: 1 idle cycle.
- overrun_o registered, high for exactly one cycle after the offending edge.

## Configuration
- RESULT_DRAIN_SUMMARY_EN defined: after the last element, STAT state emits one extra word, data_o = ouflow snapshot zero-extended to BUS_WIDTH, ouflow_elem_o = OR of all flags, idx_o = 0; last_o moves to this word. Requires MAX_DIM*MAX_DIM <= BUS_WIDTH (elaboration error otherwise).
- Not defined: no STAT state, drain is exactly MAX_DIM*MAX_DIM words, last_o on the final element.

## Structure
- Shared package result_drain_pkg: state enum (IDLE, SEND, STAT), MAX_DIM and element-count functions of BUS_WIDTH/DATA_WIDTH, index width constant.
- One sub-module natural: drain_sel, combinational element/flag selector from the snapshot by idx.

## Test plan
Defaults (MAX_DIM=4), element k = 32'h100+k, ouflow_i = 16'h8001.
- ready_i=1, done_i pulse -> 16 words 32'h100..32'h10F in consecutive cycles, idx 0..15, ouflow_elem_o high at idx 0 and 15, last_o at idx 15.
- ready_i toggling 1/0 randomly -> same 16-word sequence, data held during stalls, no duplicates.
- Second done edge at word 5 with different fin_r_i -> overrun_o one-cycle pulse, remaining words still 32'h105..32'h10F.
- rst_ni low at word 8 -> all outputs 0 immediately; next done edge restarts at idx 0 with new data.
- done_i held high across drain end -> no second drain; drop/raise done_i -> new drain after 1 cycle.
- RESULT_DRAIN_SUMMARY_EN: 17th word = 32'h0000_8001, ouflow_elem_o 1, last_o only on it.
